// File: rtl/hdmi_vid_pattern_gen.sv
// Two-pixel-per-clock video timing and test-pattern source for the HDMI TX vid_* interface.
// Counters walk pixel pairs (h) and lines (v); all outputs leave through one register stage.
module hdmi_vid_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FRONT  = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FRONT  = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        vid_clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  input  logic [47:0] solid_rgb,
  output logic [1:0]  vid_de,
  output logic [1:0]  vid_hsync,
  output logic [1:0]  vid_vsync,
  output logic [95:0] vid_data,
  output logic        frame_start
);

  localparam int HT = (H_ACTIVE + H_FRONT + H_SYNC + H_BACK) / 2;
  localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] HT_LAST  = 16'(HT - 1);
  localparam logic [15:0] HA_PAIRS = 16'(H_ACTIVE / 2);
  localparam logic [15:0] HS_BEG   = 16'((H_ACTIVE + H_FRONT) / 2);
  localparam logic [15:0] HS_END   = 16'((H_ACTIVE + H_FRONT + H_SYNC) / 2);
  localparam logic [15:0] VT_LAST  = 16'(VT - 1);
  localparam logic [15:0] VA_LINES = 16'(V_ACTIVE);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 16 - 1);
  localparam logic        HS_ACT   = 1'(HS_POL);
  localparam logic        VS_ACT   = 1'(VS_POL);

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic [15:0] bar_rem;
  logic [2:0]  bar_idx;
  logic [1:0]  pat_q;
  logic [47:0] solid_q;

  logic        frame_first;
  logic        active;
  logic        hs_on;
  logic        vs_on;
  logic [1:0]  cur_pat;
  logic [47:0] cur_solid;
  logic [47:0] pix0;
  logic [47:0] pix1;
  logic [7:0]  ramp0;
  logic [7:0]  ramp1;
  logic        chk_black;

  assign frame_first = en && (h_cnt == 16'd0) && (v_cnt == 16'd0);
  assign active      = (h_cnt < HA_PAIRS) && (v_cnt < VA_LINES);
  assign hs_on       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // The first pair of a frame already uses the freshly sampled selection.
  assign cur_pat   = frame_first ? pat_sel : pat_q;
  assign cur_solid = frame_first ? solid_rgb : solid_q;

  always_ff @(posedge vid_clk) begin
    if (reset || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HT_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VT_LAST) ? 16'd0 : v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  // Bar position: down-counter per bar, reloaded at line wrap so it tracks h_cnt.
  always_ff @(posedge vid_clk) begin
    if (reset || !en || (h_cnt == HT_LAST)) begin
      bar_rem <= BAR_LAST;
      bar_idx <= '0;
    end else if (h_cnt < HA_PAIRS) begin
      if (bar_rem == 16'd0) begin
        bar_rem <= BAR_LAST;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_rem <= bar_rem - 16'd1;
      end
    end
  end

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      pat_q   <= '0;
      solid_q <= '0;
    end else if (frame_first) begin
      pat_q   <= pat_sel;
      solid_q <= solid_rgb;
    end
  end

  assign ramp0     = {h_cnt[6:0], 1'b0};
  assign ramp1     = {h_cnt[6:0], 1'b1};
  assign chk_black = h_cnt[4] ^ v_cnt[5];

  always_comb begin
    pix0 = '0;
    pix1 = '0;
    case (cur_pat)
      2'd0: begin
        // Bar order white..black falls out of inverted index bits.
        pix0 = {{16{~bar_idx[1]}}, {16{~bar_idx[2]}}, {16{~bar_idx[0]}}};
        pix1 = pix0;
      end
      2'd1: begin
        pix0 = {3{ramp0, ramp0}};
        pix1 = {3{ramp1, ramp1}};
      end
      2'd2: begin
        pix0 = cur_solid;
        pix1 = cur_solid;
      end
      default: begin
        pix0 = chk_black ? 48'h0 : {48{1'b1}};
        pix1 = pix0;
      end
    endcase
  end

  always_ff @(posedge vid_clk) begin
    if (reset || !en) begin
      vid_de      <= 2'b00;
      vid_hsync   <= {2{~HS_ACT}};
      vid_vsync   <= {2{~VS_ACT}};
      vid_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      vid_de      <= {2{active}};
      vid_hsync   <= {2{hs_on ? HS_ACT : ~HS_ACT}};
      vid_vsync   <= {2{vs_on ? VS_ACT : ~VS_ACT}};
      vid_data    <= active ? {pix1, pix0} : 96'h0;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_hdmi_vid_pattern_gen.sv
// Directed bench: a 1080p instance checked at line level and a tiny-timing instance for frame,
// vsync, pattern-latch and enable behaviour.
module tb_hdmi_vid_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_reset, d_en;
  logic [1:0]  d_pat;
  logic [47:0] d_solid;
  logic [1:0]  d_de, d_hs, d_vs;
  logic [95:0] d_data;
  logic        d_fs;

  logic        s_reset, s_en;
  logic [1:0]  s_pat;
  logic [47:0] s_solid;
  logic [1:0]  s_de, s_hs, s_vs;
  logic [95:0] s_data;
  logic        s_fs;

  int checks = 0;
  int failures = 0;
  int pos = 0;
  int spos = 0;

  localparam logic [95:0] WHITE  = {96{1'b1}};
  localparam logic [95:0] YELLOW = {2{48'hFFFF_FFFF_0000}};
  localparam logic [95:0] CYAN   = {2{48'h0000_FFFF_FFFF}};
  localparam logic [95:0] SOLID  = {2{48'h1234_5678_9ABC}};

  hdmi_vid_pattern_gen dut (
    .vid_clk(clk), .reset(d_reset), .en(d_en), .pat_sel(d_pat), .solid_rgb(d_solid),
    .vid_de(d_de), .vid_hsync(d_hs), .vid_vsync(d_vs), .vid_data(d_data), .frame_start(d_fs)
  );

  hdmi_vid_pattern_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .vid_clk(clk), .reset(s_reset), .en(s_en), .pat_sel(s_pat), .solid_rgb(s_solid),
    .vid_de(s_de), .vid_hsync(s_hs), .vid_vsync(s_vs), .vid_data(s_data), .frame_start(s_fs)
  );

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    pos  += n;
    spos += n;
  endtask

  task automatic go(input int target);
    adv(target - pos);
  endtask

  task automatic sgo(input int target);
    adv(target - spos);
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    d_reset = 1'b1; d_en = 1'b0; d_pat = 2'd0; d_solid = '0;
    s_reset = 1'b1; s_en = 1'b0; s_pat = 2'd0; s_solid = '0;
    adv(3);
    chk("rst_de", 96'(d_de), 96'd0);
    chk("rst_hs", 96'(d_hs), 96'd0);
    chk("rst_vs", 96'(d_vs), 96'd0);
    chk("rst_data", d_data, 96'd0);
    chk("rst_fs", 96'(d_fs), 96'd0);

    // 1080p instance: bars, line timing
    d_reset = 1'b0; s_reset = 1'b0; d_en = 1'b1;
    adv(1); pos = 0;
    chk("bar_p0_fs", 96'(d_fs), 96'd1);
    chk("bar_p0_de", 96'(d_de), 96'd3);
    chk("bar_p0_data", d_data, WHITE);
    chk("p0_vs", 96'(d_vs), 96'd0);
    chk("s_idle_de", 96'(s_de), 96'd0);
    go(1);    chk("p1_fs", 96'(d_fs), 96'd0);
    go(120);  chk("bar_p120_yellow", d_data, YELLOW);
    go(959);  chk("bar_p959_black", d_data, 96'd0);
              chk("p959_de", 96'(d_de), 96'd3);
    go(960);  chk("p960_de", 96'(d_de), 96'd0);
              chk("p960_data", d_data, 96'd0);
    go(1003); chk("p1003_hs", 96'(d_hs), 96'd0);
    go(1004); chk("p1004_hs", 96'(d_hs), 96'd3);
    go(1025); chk("p1025_hs", 96'(d_hs), 96'd3);
    go(1026); chk("p1026_hs", 96'(d_hs), 96'd0);
    go(1100); chk("line1_de", 96'(d_de), 96'd3);
              chk("line1_fs", 96'(d_fs), 96'd0);
    go(11299); chk("l10_p299_cyan", d_data, CYAN);

    // reset mid-line (counters at pair 300, line 10), restart with ramp
    d_reset = 1'b1; d_pat = 2'd1;
    adv(1);
    chk("midrst_de", 96'(d_de), 96'd0);
    chk("midrst_hs", 96'(d_hs), 96'd0);
    chk("midrst_data", d_data, 96'd0);
    chk("midrst_fs", 96'(d_fs), 96'd0);
    d_reset = 1'b0;
    adv(1); pos = 0;
    chk("ramp_p0_fs", 96'(d_fs), 96'd1);
    chk("ramp_p0", d_data, {48'h0101_0101_0101, 48'h0});
    go(128); chk("ramp_p128", d_data, {48'h0101_0101_0101, 48'h0});

    // checkerboard
    d_reset = 1'b1; d_pat = 2'd3;
    adv(1);
    d_reset = 1'b0;
    adv(1); pos = 0;
    chk("chk_p0_white", d_data, WHITE);
    go(16);    chk("chk_l0_p16_black", d_data, 96'd0);
               chk("chk_l0_p16_de", 96'(d_de), 96'd3);
    go(35216); chk("chk_l32_p16_white", d_data, WHITE);
    d_en = 1'b0;

    // small instance: HT=11 pairs, VT=7 lines
    s_en = 1'b1;
    adv(1); spos = 0;
    chk("s_p0_fs", 96'(s_fs), 96'd1);
    chk("s_p0_white", s_data, WHITE);
    sgo(1);  chk("s_p1_yellow", s_data, YELLOW);
    sgo(7);  chk("s_p7_black", s_data, 96'd0);
             chk("s_p7_de", 96'(s_de), 96'd3);
    sgo(8);  chk("s_p8_de", 96'(s_de), 96'd0);
    sgo(9);  chk("s_p9_hs", 96'(s_hs), 96'd3);
    sgo(10); chk("s_p10_hs", 96'(s_hs), 96'd0);
    sgo(11); chk("s_l1_de", 96'(s_de), 96'd3);
             chk("s_l1_fs", 96'(s_fs), 96'd0);
    sgo(22);
    s_pat = 2'd2; s_solid = 48'h1234_5678_9ABC;
    sgo(24); chk("s_l2_p2_still_bars", s_data, CYAN);
    sgo(54); chk("s_l4_vs", 96'(s_vs), 96'd0);
    sgo(55); chk("s_l5_vs", 96'(s_vs), 96'd3);
             chk("s_l5_de", 96'(s_de), 96'd0);
    sgo(65); chk("s_l5_p10_vs", 96'(s_vs), 96'd3);
    sgo(66); chk("s_l6_vs", 96'(s_vs), 96'd0);
    sgo(77); chk("s_f1_fs", 96'(s_fs), 96'd1);
             chk("s_f1_solid", s_data, SOLID);
    sgo(80); chk("s_f1_p3_solid", s_data, SOLID);

    // enable dropped mid-line
    s_en = 1'b0;
    adv(1);
    chk("s_dis_de", 96'(s_de), 96'd0);
    chk("s_dis_data", s_data, 96'd0);
    chk("s_dis_fs", 96'(s_fs), 96'd0);
    adv(6);
    chk("s_dis_hold_de", 96'(s_de), 96'd0);
    chk("s_dis_hold_hs", 96'(s_hs), 96'd0);
    s_en = 1'b1;
    adv(1); spos = 0;
    chk("s_reen_fs", 96'(s_fs), 96'd1);
    chk("s_reen_data", s_data, SOLID);
    sgo(1);  chk("s_reen_p1_fs", 96'(s_fs), 96'd0);
    sgo(8);  chk("s_reen_p8_de", 96'(s_de), 96'd0);
    sgo(9);  chk("s_reen_p9_hs", 96'(s_hs), 96'd3);
    sgo(55); chk("s_reen_l5_vs", 96'(s_vs), 96'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
